fb_memstage: RTL and testbench
==============================

Name: fb_memstage

Overview:
- MEM stage of the Firebird 5-stage pipeline. Sits between the EX/MEM pipeline register and the WB stage.
- Performs load/store accesses through a req/gnt/rvalid data-memory port and stalls the upstream pipeline while an access is outstanding.
- Contains the MEM/WB pipeline register.
- Detects misaligned word accesses and bus timeouts.

Parameters:
- MAX_WAIT, 64, max cycles spent in REQ+WAIT before abort with bus error (>=2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_mem_read  in  1  load request from EX/MEM
- mem_mem_write  in  1  store request from EX/MEM
- mem_mem_to_reg  in  1  WB select memory data
- mem_reg_write  in  1  WB register write enable
- mem_alu_res  in  32  address / ALU result
- mem_rs2_data  in  32  store data
- mem_register_rd  in  5  destination register
- dmem_req  out  1  memory request, held until dmem_gnt
- dmem_we  out  1  1=store, 0=load
- dmem_addr  out  32  word address (latched alu_res)
- dmem_wdata  out  32  store data (latched rs2_data)
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  load data valid (never in the same cycle as its gnt)
- dmem_rdata  in  32  load data
- mem_stall  out  1  combinational; when high, EX/MEM and earlier stages hold (we=0)
- misalign_exc  out  1  one-cycle registered pulse, misaligned access
- bus_err  out  1  one-cycle registered pulse, timeout
- wb_mem_to_reg  out  1
- wb_reg_write  out  1
- wb_alu_res  out  32
- wb_mem_data  out  32
- wb_register_rd  out  5

Behaviour:
- access = mem_mem_read | mem_mem_write; read has priority if both are set (treated as a load).
- aligned = (mem_alu_res[1:0] == 2'b00).
- Reset: state=IDLE, wait counter=0, rdata buffer=0. All outputs 0: dmem_*, misalign_exc, bus_err, all wb_*.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE:
    - access & aligned: latch addr/wdata/we, go to REQ.
    - access & !aligned: no request; misalign_exc=1 next cycle; treated as completed this cycle with wb_reg_write forced 0.
  - REQ: dmem_req=1.
    - dmem_gnt & store: go to DONE.
    - dmem_gnt & load: go to WAIT.
  - WAIT: dmem_req=0.
    - dmem_rvalid: capture dmem_rdata into buffer, go to DONE.
  - DONE: one cycle; return to IDLE unconditionally. EX/MEM loads the next instruction this cycle, so the same instruction is never re-issued.
- Timeout: counter clears on IDLE->REQ and increments each cycle in REQ/WAIT. When it reaches MAX_WAIT-1 without completion:
  - drop dmem_req;
  - bus_err=1 next cycle;
  - go to DONE with the abort flag set (wb_reg_write forced 0).
- mem_stall = (IDLE & access & aligned) | REQ | WAIT. mem_stall=0 in DONE and on a non-access/misaligned IDLE cycle.
- Best-case latency:
  - store = 3 cycles in MEM (IDLE, REQ with gnt, DONE);
  - load = 4 cycles (+1 WAIT minimum).
- MEM/WB register, every cycle without rst:
  - mem_stall=0: wb_mem_to_reg, wb_reg_write (forced 0 if misaligned or aborted), wb_alu_res, wb_register_rd take the mem_* inputs. wb_mem_data = rdata buffer for a completed load, else 0.
  - mem_stall=1: bubble. wb_reg_write=0, wb_mem_to_reg=0; the other wb_* hold.
- dmem_rvalid or dmem_gnt outside their expected state is ignored.
- rst mid-access: immediate return to IDLE, req drops; a late rvalid after reset is ignored.
- Non-access instructions pass through with 1-cycle register latency and no stall.

Test Plan:
- Reset, then ALU op (reg_write=1, alu_res=0x1234, rd=5, no access) -> next cycle wb_alu_res=0x1234, wb_rd=5, wb_reg_write=1, mem_stall never high.
- Store addr=0x100, data=0xDEADBEEF, gnt 2 cycles after req -> dmem_req high exactly until gnt, dmem_we=1, dmem_addr=0x100, dmem_wdata=0xDEADBEEF, mem_stall high for 3 cycles, wb_reg_write=0 for the store.
- Load addr=0x200, gnt immediately, rvalid 3 cycles later with 0xCAFEF00D, rd=7 -> wb_mem_data=0xCAFEF00D, wb_mem_to_reg=1, wb_reg_write=1, wb_rd=7 exactly once; bubble (wb_reg_write=0) during stall.
- Load addr=0x202 -> no dmem_req, misalign_exc pulses 1 cycle, wb_reg_write=0, mem_stall=0.
- Load with gnt never asserted, MAX_WAIT=64 -> dmem_req drops after 64 cycles in REQ, bus_err 1-cycle pulse, wb_reg_write=0, FSM back to IDLE, next instruction proceeds.
- rst asserted while in WAIT, rvalid arrives 2 cycles later -> all outputs 0 after reset, rvalid ignored, no WB write.

Source files
------------

// File: rtl/fb_memstage.sv
// fb_memstage: MEM stage of the Firebird pipeline, with a req/gnt/rvalid data port and the MEM/WB register.
// Latency: non-access ops take 1 cycle; a store takes >=3 cycles in MEM and a load takes >=4.
//   The MEM/WB register adds one further cycle.
// Backpressure: mem_stall holds EX/MEM while an access is outstanding. A bus timeout after MAX_WAIT cycles aborts the access.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   mem_*                          instruction fields from the EX/MEM register
//   dmem_req/we/addr/wdata         request side of the data-memory port (addr/wdata/we latched at issue)
//   dmem_gnt/rvalid/rdata          grant and load-response side of the data-memory port
//   mem_stall                      combinational hold for EX/MEM and earlier stages
//   misalign_exc, bus_err          one-cycle registered exception pulses
//   wb_*                           MEM/WB pipeline register outputs
module fb_memstage #(
  parameter int MAX_WAIT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_mem_read,
  input  logic        mem_mem_write,
  input  logic        mem_mem_to_reg,
  input  logic        mem_reg_write,
  input  logic [31:0] mem_alu_res,
  input  logic [31:0] mem_rs2_data,
  input  logic [4:0]  mem_register_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        misalign_exc,
  output logic        bus_err,
  output logic        wb_mem_to_reg,
  output logic        wb_reg_write,
  output logic [31:0] wb_alu_res,
  output logic [31:0] wb_mem_data,
  output logic [4:0]  wb_register_rd
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam int CW = $clog2(MAX_WAIT);

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   rdata_buf;
  logic          abort_q;
  logic          access, aligned, start, misalign, cnt_expired, timeout;
  logic          load_done_ok;

  assign access      = mem_mem_read | mem_mem_write;
  assign aligned     = (mem_alu_res[1:0] == 2'b00);
  assign start       = (state == IDLE) & access & aligned;
  assign misalign    = (state == IDLE) & access & ~aligned;
  assign cnt_expired = (wait_cnt == CW'(MAX_WAIT - 1));
  // A load that reached DONE through rvalid (not through the timeout path).
  assign load_done_ok = (state == DONE) & ~dmem_we & ~abort_q;

  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    dmem_req  = 1'b0;
    mem_stall = 1'b0;
    unique case (state)
      IDLE: begin
        mem_stall = start;
        if (start) state_nxt = REQ;
      end
      REQ: begin
        dmem_req  = 1'b1;
        mem_stall = 1'b1;
        // A store grant completes the access, so it wins over an expiring counter.
        if (dmem_gnt && dmem_we) begin
          state_nxt = DONE;
        end else if (cnt_expired) begin
          state_nxt = DONE;
          timeout   = 1'b1;
        end else if (dmem_gnt) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        mem_stall = 1'b1;
        if (dmem_rvalid) begin
          state_nxt = DONE;
        end else if (cnt_expired) begin
          state_nxt = DONE;
          timeout   = 1'b1;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      rdata_buf      <= '0;
      abort_q        <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      misalign_exc   <= 1'b0;
      bus_err        <= 1'b0;
      wb_mem_to_reg  <= 1'b0;
      wb_reg_write   <= 1'b0;
      wb_alu_res     <= '0;
      wb_mem_data    <= '0;
      wb_register_rd <= '0;
    end else begin
      state        <= state_nxt;
      misalign_exc <= misalign;
      bus_err      <= timeout;

      if (start) begin
        // Read has priority when both read and write are set.
        dmem_we    <= ~mem_mem_read;
        dmem_addr  <= mem_alu_res;
        dmem_wdata <= mem_rs2_data;
        wait_cnt   <= '0;
        abort_q    <= 1'b0;
      end else if (state == REQ || state == WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (timeout) abort_q <= 1'b1;

      if (state == WAIT && dmem_rvalid) rdata_buf <= dmem_rdata;

      // The MEM/WB register inserts a bubble while stalled. On the releasing cycle it takes the
      // still-held EX/MEM fields.
      if (mem_stall) begin
        wb_reg_write  <= 1'b0;
        wb_mem_to_reg <= 1'b0;
      end else begin
        wb_mem_to_reg  <= mem_mem_to_reg;
        wb_reg_write   <= mem_reg_write & ~misalign & ~((state == DONE) & abort_q);
        wb_alu_res     <= mem_alu_res;
        wb_register_rd <= mem_register_rd;
        wb_mem_data    <= load_done_ok ? rdata_buf : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_fb_memstage.sv
// tb_fb_memstage: directed self-checking bench for fb_memstage.
// Latency: each test task drives one or more instructions and checks the MEM/WB outputs that follow.
// Backpressure: the bench answers dmem_req with gnt and rvalid at scripted cycle offsets.
module tb_fb_memstage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write;
  logic [31:0] mem_alu_res, mem_rs2_data;
  logic [4:0]  mem_register_rd;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        mem_stall, misalign_exc, bus_err;
  logic        wb_mem_to_reg, wb_reg_write;
  logic [31:0] wb_alu_res, wb_mem_data;
  logic [4:0]  wb_register_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fb_memstage #(.MAX_WAIT(64)) dut (
    .clk(clk), .rst(rst),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_reg_write(mem_reg_write),
    .mem_alu_res(mem_alu_res), .mem_rs2_data(mem_rs2_data),
    .mem_register_rd(mem_register_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
    .misalign_exc(misalign_exc), .bus_err(bus_err),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write),
    .wb_alu_res(wb_alu_res), .wb_mem_data(wb_mem_data),
    .wb_register_rd(wb_register_rd)
  );

  task automatic set_instr(input logic rd, input logic wr, input logic mtr, input logic rw,
                           input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rdi);
    mem_mem_read = rd; mem_mem_write = wr; mem_mem_to_reg = mtr; mem_reg_write = rw;
    mem_alu_res = alu; mem_rs2_data = rs2; mem_register_rd = rdi;
  endtask

  task automatic nop();
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  // Drives one instruction until MEM releases it (mem_stall low), acting as the memory.
  // gnt_at: index of the req cycle that gets a grant (0 = never).
  // rv_at: WAIT cycle that gets rvalid.
  // Returns at posedge+2 after the MEM/WB register has captured the instruction, with nop driven.
  task automatic run_access(input logic rd, input logic wr, input logic mtr, input logic rw,
                            input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rdi,
                            input int gnt_at, input int rv_at, input logic [31:0] rdata,
                            output int stall_n, output int req_n, output int wbw_n, output int berr_n,
                            output logic [31:0] addr_o, output logic [31:0] wdata_o,
                            output logic we_o, output bit released);
    int  wait_n;
    bit  granted;
    stall_n = 0; req_n = 0; wbw_n = 0; berr_n = 0; wait_n = 0; granted = 0;
    addr_o = 32'h0; wdata_o = 32'h0; we_o = 1'b0; released = 0;
    @(posedge clk); #1;
    set_instr(rd, wr, mtr, rw, alu, rs2, rdi);
    for (int c = 0; c < 200; c++) begin
      #1;
      if (c > 0 && wb_reg_write) wbw_n++;
      if (bus_err) berr_n++;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      if (dmem_req) begin
        req_n++; addr_o = dmem_addr; wdata_o = dmem_wdata; we_o = dmem_we;
        if (req_n == gnt_at) begin dmem_gnt = 1'b1; granted = 1; end
      end else if (granted) begin
        wait_n++;
        if (wait_n == rv_at) begin dmem_rvalid = 1'b1; dmem_rdata = rdata; end
      end
      #1;
      if (mem_stall) stall_n++;
      else begin released = 1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    nop(); dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; nop(); dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin errors++; $display("FAIL reset_dmem_ctl req=%b we=%b want 0 0", dmem_req, dmem_we); end
    checks++; if (dmem_addr !== 32'h0 || dmem_wdata !== 32'h0) begin errors++; $display("FAIL reset_dmem_bus addr=%h wdata=%h want 0", dmem_addr, dmem_wdata); end
    checks++; if (mem_stall !== 1'b0 || misalign_exc !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL reset_flags stall=%b mis=%b berr=%b want 0", mem_stall, misalign_exc, bus_err); end
    checks++; if ({wb_mem_to_reg, wb_reg_write, wb_alu_res, wb_mem_data, wb_register_rd} !== 71'h0) begin errors++; $display("FAIL reset_wb mtr=%b rw=%b alu=%h md=%h rd=%0d want 0", wb_mem_to_reg, wb_reg_write, wb_alu_res, wb_mem_data, wb_register_rd); end
    rst = 1'b0;
  endtask

  task automatic test_alu_op();
    int s, r, w, b; logic [31:0] a, d; logic we; bit ok;
    run_access(1'b0, 1'b0, 1'b0, 1'b1, 32'h1234, 32'h0, 5'd5, 0, 0, 32'h0, s, r, w, b, a, d, we, ok);
    checks++; if (s !== 0 || r !== 0) begin errors++; $display("FAIL alu_stall stall_cycles=%0d req_cycles=%0d want 0 0", s, r); end
    checks++; if (wb_alu_res !== 32'h1234 || wb_register_rd !== 5'd5) begin errors++; $display("FAIL alu_wb alu=%h rd=%0d want 1234 5", wb_alu_res, wb_register_rd); end
    checks++; if (wb_reg_write !== 1'b1 || wb_mem_to_reg !== 1'b0 || wb_mem_data !== 32'h0) begin errors++; $display("FAIL alu_wb_ctl rw=%b mtr=%b md=%h want 1 0 0", wb_reg_write, wb_mem_to_reg, wb_mem_data); end
  endtask

  task automatic test_store();
    int s, r, w, b; logic [31:0] a, d; logic we; bit ok;
    run_access(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF, 5'd3, 2, 0, 32'h0, s, r, w, b, a, d, we, ok);
    checks++; if (!ok) begin errors++; $display("FAIL store_release stall never dropped"); end
    checks++; if (s !== 3 || r !== 2) begin errors++; $display("FAIL store_timing stall_cycles=%0d req_cycles=%0d want 3 2", s, r); end
    checks++; if (we !== 1'b1 || a !== 32'h100 || d !== 32'hDEADBEEF) begin errors++; $display("FAIL store_bus we=%b addr=%h wdata=%h want 1 100 deadbeef", we, a, d); end
    checks++; if (wb_reg_write !== 1'b0 || w !== 0 || b !== 0) begin errors++; $display("FAIL store_wb rw=%b bubble_writes=%0d berr=%0d want 0 0 0", wb_reg_write, w, b); end
    checks++; if (wb_alu_res !== 32'h100 || wb_mem_data !== 32'h0) begin errors++; $display("FAIL store_wb_data alu=%h md=%h want 100 0", wb_alu_res, wb_mem_data); end
  endtask

  task automatic test_load();
    int s, r, w, b; logic [31:0] a, d; logic we; bit ok;
    run_access(1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 32'h0, 5'd7, 1, 3, 32'hCAFEF00D, s, r, w, b, a, d, we, ok);
    checks++; if (!ok || s !== 5 || r !== 1) begin errors++; $display("FAIL load_timing released=%0d stall_cycles=%0d req_cycles=%0d want 1 5 1", ok, s, r); end
    checks++; if (we !== 1'b0 || a !== 32'h200) begin errors++; $display("FAIL load_bus we=%b addr=%h want 0 200", we, a); end
    checks++; if (w !== 0) begin errors++; $display("FAIL load_bubble writes_during_stall=%0d want 0", w); end
    checks++; if (wb_mem_data !== 32'hCAFEF00D || wb_mem_to_reg !== 1'b1) begin errors++; $display("FAIL load_wb_data md=%h mtr=%b want cafef00d 1", wb_mem_data, wb_mem_to_reg); end
    checks++; if (wb_reg_write !== 1'b1 || wb_register_rd !== 5'd7) begin errors++; $display("FAIL load_wb_ctl rw=%b rd=%0d want 1 7", wb_reg_write, wb_register_rd); end
    @(posedge clk); #2;
    checks++; if (wb_reg_write !== 1'b0 || wb_mem_data !== 32'h0) begin errors++; $display("FAIL load_once rw=%b md=%h want 0 0", wb_reg_write, wb_mem_data); end
  endtask

  task automatic test_misaligned();
    int s, r, w, b; logic [31:0] a, d; logic we; bit ok;
    run_access(1'b1, 1'b0, 1'b1, 1'b1, 32'h202, 32'h0, 5'd8, 1, 1, 32'h0, s, r, w, b, a, d, we, ok);
    checks++; if (s !== 0 || r !== 0) begin errors++; $display("FAIL misalign_noreq stall_cycles=%0d req_cycles=%0d want 0 0", s, r); end
    checks++; if (misalign_exc !== 1'b1 || wb_reg_write !== 1'b0) begin errors++; $display("FAIL misalign_exc exc=%b rw=%b want 1 0", misalign_exc, wb_reg_write); end
    checks++; if (wb_alu_res !== 32'h202) begin errors++; $display("FAIL misalign_wb_alu alu=%h want 202", wb_alu_res); end
    @(posedge clk); #2;
    checks++; if (misalign_exc !== 1'b0) begin errors++; $display("FAIL misalign_pulse exc=%b want 0", misalign_exc); end
    run_access(1'b0, 1'b1, 1'b0, 1'b0, 32'h101, 32'h5, 5'd0, 1, 0, 32'h0, s, r, w, b, a, d, we, ok);
    checks++; if (s !== 0 || r !== 0 || misalign_exc !== 1'b1) begin errors++; $display("FAIL misalign_store stall_cycles=%0d req_cycles=%0d exc=%b want 0 0 1", s, r, misalign_exc); end
  endtask

  task automatic test_timeout();
    int s, r, w, b; logic [31:0] a, d; logic we; bit ok;
    run_access(1'b1, 1'b0, 1'b1, 1'b1, 32'h400, 32'h0, 5'd9, 0, 0, 32'h0, s, r, w, b, a, d, we, ok);
    checks++; if (!ok || r !== 64 || s !== 65) begin errors++; $display("FAIL timeout_len released=%0d req_cycles=%0d stall_cycles=%0d want 1 64 65", ok, r, s); end
    checks++; if (b !== 1 || bus_err !== 1'b0) begin errors++; $display("FAIL timeout_berr pulses=%0d after=%b want 1 0", b, bus_err); end
    checks++; if (wb_reg_write !== 1'b0 || wb_mem_data !== 32'h0 || dmem_req !== 1'b0) begin errors++; $display("FAIL timeout_wb rw=%b md=%h req=%b want 0 0 0", wb_reg_write, wb_mem_data, dmem_req); end
    run_access(1'b0, 1'b0, 1'b0, 1'b1, 32'h77, 32'h0, 5'd12, 0, 0, 32'h0, s, r, w, b, a, d, we, ok);
    checks++; if (s !== 0 || wb_reg_write !== 1'b1 || wb_alu_res !== 32'h77 || wb_register_rd !== 5'd12) begin errors++; $display("FAIL timeout_next stall_cycles=%0d rw=%b alu=%h rd=%0d want 0 1 77 12", s, wb_reg_write, wb_alu_res, wb_register_rd); end
  endtask

  task automatic test_back_to_back();
    int s, r, w, b; logic [31:0] a, d; logic we; bit ok;
    // Read and write both set behaves as a load; the best-case load takes 3 stall cycles.
    run_access(1'b1, 1'b1, 1'b1, 1'b1, 32'h500, 32'h9, 5'd4, 1, 1, 32'h0BADF00D, s, r, w, b, a, d, we, ok);
    checks++; if (we !== 1'b0 || s !== 3) begin errors++; $display("FAIL rw_both we=%b stall_cycles=%0d want 0 3", we, s); end
    checks++; if (wb_mem_data !== 32'h0BADF00D || wb_reg_write !== 1'b1 || wb_register_rd !== 5'd4) begin errors++; $display("FAIL rw_both_wb md=%h rw=%b rd=%0d want 0badf00d 1 4", wb_mem_data, wb_reg_write, wb_register_rd); end
    run_access(1'b0, 1'b1, 1'b0, 1'b0, 32'h504, 32'h1111, 5'd0, 1, 0, 32'h0, s, r, w, b, a, d, we, ok);
    checks++; if (s !== 2 || r !== 1 || d !== 32'h1111 || wb_mem_data !== 32'h0) begin errors++; $display("FAIL store_fast stall_cycles=%0d req_cycles=%0d wdata=%h md=%h want 2 1 1111 0", s, r, d, wb_mem_data); end
  endtask

  task automatic test_reset_in_wait();
    @(posedge clk); #1;
    set_instr(1'b1, 1'b0, 1'b1, 1'b1, 32'h300, 32'h0, 5'd9);
    @(posedge clk); #1;
    dmem_gnt = dmem_req;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    checks++; if (dmem_req !== 1'b0 || mem_stall !== 1'b1) begin errors++; $display("FAIL rstwait_in_wait req=%b stall=%b want 0 1", dmem_req, mem_stall); end
    rst = 1'b1; nop();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_addr !== 32'h0 || mem_stall !== 1'b0) begin errors++; $display("FAIL rstwait_dmem req=%b we=%b addr=%h stall=%b want 0 0 0 0", dmem_req, dmem_we, dmem_addr, mem_stall); end
    checks++; if ({wb_mem_to_reg, wb_reg_write, wb_alu_res, wb_mem_data, wb_register_rd} !== 71'h0) begin errors++; $display("FAIL rstwait_wb rw=%b alu=%h rd=%0d want 0", wb_reg_write, wb_alu_res, wb_register_rd); end
    @(posedge clk); #1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h55;
    #1;
    checks++; if (mem_stall !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL rstwait_late_rvalid stall=%b req=%b want 0 0", mem_stall, dmem_req); end
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    #1;
    checks++; if (wb_reg_write !== 1'b0 || wb_mem_data !== 32'h0 || bus_err !== 1'b0) begin errors++; $display("FAIL rstwait_no_wb rw=%b md=%h berr=%b want 0 0 0", wb_reg_write, wb_mem_data, bus_err); end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_store();
    test_load();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
